// File: rtl/elgamal_enc_ctrl.sv
// ElGamal encryption sequencer: c1 = g^k mod p, c2 = m*(y^k mod p) mod p using one
// shared mod_exp engine and one modular multiplier, each reset before every use.
module elgamal_enc_ctrl #(
  parameter int SIZE    = 64,
  parameter int TIMEOUT = 1 << 20,
  parameter int RST_LEN = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] req_g,
  input  logic [SIZE-1:0] req_y,
  input  logic [SIZE-1:0] req_k,
  input  logic [SIZE-1:0] req_m,
  input  logic [SIZE-1:0] req_p,
  input  logic            req_tvalid,
  output logic            req_tready,
  output logic            exp_rst,
  output logic [SIZE-1:0] exp_base,
  output logic [SIZE-1:0] exp_power,
  output logic [SIZE-1:0] exp_modulus,
  output logic            exp_in_tvalid,
  input  logic            exp_in_tready,
  input  logic [SIZE-1:0] exp_out_tdata,
  input  logic            exp_out_tvalid,
  output logic            exp_out_tready,
  output logic            mul_rst,
  output logic [SIZE-1:0] mul_a,
  output logic [SIZE-1:0] mul_b,
  output logic [SIZE-1:0] mul_mod,
  output logic            mul_in_tvalid,
  input  logic [SIZE-1:0] mul_out_tdata,
  input  logic            mul_out_tvalid,
  output logic            mul_out_tready,
  output logic [SIZE-1:0] c1_tdata,
  output logic [SIZE-1:0] c2_tdata,
  output logic            out_tvalid,
  input  logic            out_tready,
  output logic            err,
  output logic            busy
);
  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_E1_RST, S_E1_REQ, S_E1_WAIT, S_E2_RST, S_E2_REQ, S_E2_WAIT,
    S_M_RST, S_M_REQ, S_M_WAIT, S_OUT
  } state_e;

  localparam int RW = (RST_LEN < 2) ? 1 : $clog2(RST_LEN + 1);
  localparam logic [20:0] TO_LAST = 21'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [RW-1:0]   rcnt_q, rcnt_d, acnt_q, acnt_d;
  logic [20:0]     tcnt_q, tcnt_d;
  logic [SIZE-1:0] g_q, y_q, k_q, m_q, p_q, g_d, y_d, k_d, m_d, p_d;
  logic [SIZE-1:0] s_q, s_d, c1_q, c1_d, c2_q, c2_d, base_q;
  logic            err_q, err_d, abort, bad, timed_out;
  logic            exp_rst_q, mul_rst_q, exp_vld_q, exp_rdy_q, mul_vld_q, mul_rdy_q;
  logic            out_vld_q, req_rdy_q, busy_q;

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    tcnt_d  = tcnt_q;
    acnt_d  = (acnt_q != '0) ? acnt_q - RW'(1) : '0;
    g_d = g_q; y_d = y_q; k_d = k_q; m_d = m_q; p_d = p_q;
    s_d = s_q; c1_d = c1_q; c2_d = c2_q; err_d = err_q;
    abort     = 1'b0;
    bad       = (p_q < SIZE'(2)) || (m_q >= p_q) || (g_q >= p_q) || (y_q >= p_q);
    timed_out = (tcnt_q >= TO_LAST);
    if (state_q inside {S_E1_REQ, S_E1_WAIT, S_E2_REQ, S_E2_WAIT, S_M_REQ, S_M_WAIT})
      tcnt_d = tcnt_q + 21'd1;
    unique case (state_q)
      S_IDLE: if (req_tvalid) begin
        g_d = req_g; y_d = req_y; k_d = req_k; m_d = req_m; p_d = req_p;
        state_d = S_CHECK;
      end
      S_CHECK: if (bad) begin
        c1_d = '0; c2_d = '0; err_d = 1'b1; state_d = S_OUT;
      end else begin
        err_d = 1'b0; rcnt_d = RW'(RST_LEN - 1); state_d = S_E1_RST;
      end
      S_E1_RST, S_E2_RST, S_M_RST: begin
        if (rcnt_q != '0) rcnt_d = rcnt_q - RW'(1);
        else begin
          tcnt_d  = '0;
          state_d = (state_q == S_E1_RST) ? S_E1_REQ :
                    (state_q == S_E2_RST) ? S_E2_REQ : S_M_REQ;
        end
      end
      S_E1_REQ, S_E2_REQ: begin
        if (exp_in_tready) state_d = (state_q == S_E1_REQ) ? S_E1_WAIT : S_E2_WAIT;
        else if (timed_out) abort = 1'b1;
      end
      S_E1_WAIT: if (exp_out_tvalid) begin
        c1_d = exp_out_tdata; rcnt_d = RW'(RST_LEN - 1); state_d = S_E2_RST;
      end else if (timed_out) abort = 1'b1;
      S_E2_WAIT: if (exp_out_tvalid) begin
        s_d = exp_out_tdata; rcnt_d = RW'(RST_LEN - 1); state_d = S_M_RST;
      end else if (timed_out) abort = 1'b1;
      // The multiplier has no input ready; it takes its operands in the single valid cycle.
      S_M_REQ: state_d = S_M_WAIT;
      S_M_WAIT: if (mul_out_tvalid) begin
        c2_d = mul_out_tdata; state_d = S_OUT;
      end else if (timed_out) abort = 1'b1;
      S_OUT: if (out_tready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      c1_d = '0; c2_d = '0; err_d = 1'b1; acnt_d = RW'(RST_LEN); state_d = S_OUT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rcnt_q <= '0; acnt_q <= '0; tcnt_q <= '0;
      g_q <= '0; y_q <= '0; k_q <= '0; m_q <= '0; p_q <= '0;
      s_q <= '0; c1_q <= '0; c2_q <= '0; err_q <= 1'b0; base_q <= '0;
      exp_rst_q <= 1'b0; mul_rst_q <= 1'b0;
      exp_vld_q <= 1'b0; exp_rdy_q <= 1'b0; mul_vld_q <= 1'b0; mul_rdy_q <= 1'b0;
      out_vld_q <= 1'b0; req_rdy_q <= 1'b1; busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q <= rcnt_d; acnt_q <= acnt_d; tcnt_q <= tcnt_d;
      g_q <= g_d; y_q <= y_d; k_q <= k_d; m_q <= m_d; p_q <= p_d;
      s_q <= s_d; c1_q <= c1_d; c2_q <= c2_d; err_q <= err_d;
      base_q    <= (state_d inside {S_E2_RST, S_E2_REQ, S_E2_WAIT}) ? y_d : g_d;
      exp_rst_q <= (state_d inside {S_E1_RST, S_E2_RST}) || (acnt_d != '0);
      mul_rst_q <= (state_d == S_M_RST) || (acnt_d != '0);
      exp_vld_q <= state_d inside {S_E1_REQ, S_E2_REQ};
      exp_rdy_q <= state_d inside {S_E1_WAIT, S_E2_WAIT};
      mul_vld_q <= (state_d == S_M_REQ);
      mul_rdy_q <= (state_d == S_M_WAIT);
      out_vld_q <= (state_d == S_OUT);
      req_rdy_q <= (state_d == S_IDLE);
      busy_q    <= (state_d != S_IDLE);
    end
  end

  assign req_tready     = req_rdy_q;
  assign busy           = busy_q;
  assign exp_rst        = rst | exp_rst_q;
  assign mul_rst        = rst | mul_rst_q;
  assign exp_base       = base_q;
  assign exp_power      = k_q;
  assign exp_modulus    = p_q;
  assign exp_in_tvalid  = exp_vld_q;
  assign exp_out_tready = exp_rdy_q;
  assign mul_a          = m_q;
  assign mul_b          = s_q;
  assign mul_mod        = p_q;
  assign mul_in_tvalid  = mul_vld_q;
  assign mul_out_tready = mul_rdy_q;
  assign c1_tdata       = c1_q;
  assign c2_tdata       = c2_q;
  assign err            = err_q;
  assign out_tvalid     = out_vld_q;
endmodule

// File: tb/tb_elgamal_enc_ctrl.sv
// Bench for elgamal_enc_ctrl: behavioural engines plus an arithmetic reference for (c1, c2, err).
module tb_elgamal_enc_ctrl;
  localparam int SIZE = 64, TIMEOUT = 64, RST_LEN = 2;
  typedef logic [SIZE-1:0] word_t;

  logic  clk = 1'b0, rst = 1'b1;
  word_t req_g = '0, req_y = '0, req_k = '0, req_m = '0, req_p = '0;
  logic  req_tvalid = 1'b0, req_tready;
  logic  exp_rst, exp_in_tvalid, exp_out_tready;
  word_t exp_base, exp_power, exp_modulus;
  logic  exp_in_tready = 1'b0, exp_out_tvalid = 1'b0;
  word_t exp_out_tdata = '0;
  logic  mul_rst, mul_in_tvalid, mul_out_tready;
  word_t mul_a, mul_b, mul_mod;
  logic  mul_out_tvalid = 1'b0;
  word_t mul_out_tdata = '0;
  word_t c1_tdata, c2_tdata;
  logic  out_tvalid, err, busy;
  logic  out_tready = 1'b0;

  elgamal_enc_ctrl #(.SIZE(SIZE), .TIMEOUT(TIMEOUT), .RST_LEN(RST_LEN)) dut (
    .clk(clk), .rst(rst),
    .req_g(req_g), .req_y(req_y), .req_k(req_k), .req_m(req_m), .req_p(req_p),
    .req_tvalid(req_tvalid), .req_tready(req_tready),
    .exp_rst(exp_rst), .exp_base(exp_base), .exp_power(exp_power), .exp_modulus(exp_modulus),
    .exp_in_tvalid(exp_in_tvalid), .exp_in_tready(exp_in_tready),
    .exp_out_tdata(exp_out_tdata), .exp_out_tvalid(exp_out_tvalid), .exp_out_tready(exp_out_tready),
    .mul_rst(mul_rst), .mul_a(mul_a), .mul_b(mul_b), .mul_mod(mul_mod),
    .mul_in_tvalid(mul_in_tvalid), .mul_out_tdata(mul_out_tdata),
    .mul_out_tvalid(mul_out_tvalid), .mul_out_tready(mul_out_tready),
    .c1_tdata(c1_tdata), .c2_tdata(c2_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic word_t mulmod(input word_t a, input word_t b, input word_t m);
    logic [2*SIZE-1:0] t;
    t = {{SIZE{1'b0}}, a} * {{SIZE{1'b0}}, b};
    return word_t'(t % {{SIZE{1'b0}}, m});
  endfunction

  function automatic word_t modexp(input word_t b, input word_t e, input word_t m);
    word_t r, x;
    r = word_t'(1) % m;
    x = b % m;
    for (int i = 0; i < SIZE; i++) begin
      if (e[i]) r = mulmod(r, x, m);
      x = mulmod(x, x, m);
    end
    return r;
  endfunction

  // Engine behaviour knobs, set by the stimulus.
  int dly_max = 3, fix_dly = -1;
  bit hang_exp = 1'b0, rand_rdy = 1'b1;
  int exp_acc = 0, mul_acc = 0, e_st = 0, m_st = 0, e_cnt = 0, m_cnt = 0;
  word_t e_res = '0, m_res = '0;

  always @(posedge clk) begin
    if (exp_rst) begin
      e_st <= 0; exp_in_tready <= 1'b0; exp_out_tvalid <= 1'b0;
    end else case (e_st)
      0: if (exp_in_tvalid && exp_in_tready) begin
        e_res <= modexp(exp_base, exp_power, exp_modulus);
        e_cnt <= (fix_dly >= 0) ? fix_dly : int'($urandom_range(0, dly_max));
        exp_in_tready <= 1'b0; exp_acc <= exp_acc + 1; e_st <= 1;
      end else exp_in_tready <= rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      1: if (!hang_exp) begin
        if (e_cnt == 0) begin exp_out_tvalid <= 1'b1; exp_out_tdata <= e_res; e_st <= 2; end
        else e_cnt <= e_cnt - 1;
      end
      2: if (exp_out_tready) begin exp_out_tvalid <= 1'b0; e_st <= 3; end
      default: ;
    endcase
  end

  always @(posedge clk) begin
    if (mul_rst) begin
      m_st <= 0; mul_out_tvalid <= 1'b0;
    end else case (m_st)
      0: if (mul_in_tvalid) begin
        m_res <= mulmod(mul_a, mul_b, mul_mod);
        m_cnt <= int'($urandom_range(0, dly_max)); mul_acc <= mul_acc + 1; m_st <= 1;
      end
      1: if (m_cnt == 0) begin mul_out_tvalid <= 1'b1; mul_out_tdata <= m_res; m_st <= 2; end
         else m_cnt <= m_cnt - 1;
      2: if (mul_out_tready) begin mul_out_tvalid <= 1'b0; m_st <= 3; end
      default: ;
    endcase
  end

  // Monitor: controller reset pulses (count and length) and engine-valid activity.
  int exp_pulses = 0, mul_pulses = 0, bad_len = 0, er_len = 0, mr_len = 0, vld_cycles = 0;
  always @(posedge clk) begin
    if (rst) begin
      er_len = 0; mr_len = 0;
    end else begin
      if (exp_rst) er_len++;
      else if (er_len != 0) begin exp_pulses++; if (er_len != RST_LEN) bad_len++; er_len = 0; end
      if (mul_rst) mr_len++;
      else if (mr_len != 0) begin mul_pulses++; if (mr_len != RST_LEN) bad_len++; mr_len = 0; end
      if (exp_in_tvalid || mul_in_tvalid) vld_cycles++;
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input word_t obs, input word_t expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic send(input word_t g, input word_t y, input word_t k, input word_t m, input word_t p);
    int n = 0;
    while (!req_tready && n < 300) begin @(negedge clk); n++; end
    chkb("send:req_tready", req_tready, 1'b1);
    req_g = g; req_y = y; req_k = k; req_m = m; req_p = p; req_tvalid = 1'b1;
    @(negedge clk);
    req_tvalid = 1'b0;
  endtask

  task automatic recv(input string tag, input word_t c1e, input word_t c2e, input logic erre,
                      input int hold, output int waited);
    int n = 0;
    bit stable = 1'b1;
    word_t c1s, c2s;
    logic es;
    while (!out_tvalid && n < 400) begin @(negedge clk); n++; end
    waited = n;
    chkb({tag, ":out_tvalid"}, out_tvalid, 1'b1);
    chk({tag, ":c1"}, c1_tdata, c1e);
    chk({tag, ":c2"}, c2_tdata, c2e);
    chkb({tag, ":err"}, err, erre);
    c1s = c1_tdata; c2s = c2_tdata; es = err;
    for (int i = 0; i < hold; i++) begin
      req_g = 64'd1; req_y = 64'd1; req_k = 64'd1; req_m = 64'd1; req_p = 64'd3;
      req_tvalid = 1'b1;
      @(negedge clk);
      if (out_tvalid !== 1'b1 || c1_tdata !== c1s || c2_tdata !== c2s || err !== es ||
          req_tready !== 1'b0 || busy !== 1'b1) stable = 1'b0;
    end
    req_tvalid = 1'b0;
    if (hold > 0) chkb({tag, ":hold_stable"}, stable, 1'b1);
    out_tready = 1'b1;
    @(negedge clk);
    out_tready = 1'b0;
    chkb({tag, ":out_drop"}, out_tvalid, 1'b0);
    chkb({tag, ":back_idle"}, req_tready, 1'b1);
    chkb({tag, ":not_busy"}, busy, 1'b0);
  endtask

  task automatic run(input string tag, input word_t g, input word_t y, input word_t k,
                     input word_t m, input word_t p, input int hold, output int waited);
    bit bad;
    word_t c1e, c2e;
    bad = (p < 2) || (m >= p) || (g >= p) || (y >= p);
    c1e = bad ? '0 : modexp(g, k, p);
    c2e = bad ? '0 : mulmod(m, modexp(y, k, p), p);
    send(g, y, k, m, p);
    recv(tag, c1e, c2e, bad, hold, waited);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, ep0, mp0, bl0, v0, a0, n;
    word_t g, y, k, m, p;
    repeat (3) @(negedge clk);
    chkb("rst:exp_rst", exp_rst, 1'b1);
    chkb("rst:mul_rst", mul_rst, 1'b1);
    chkb("rst:out_tvalid", out_tvalid, 1'b0);
    chkb("rst:busy", busy, 1'b0);
    chkb("rst:err", err, 1'b0);
    chk("rst:c1", c1_tdata, 64'd0);
    chk("rst:c2", c2_tdata, 64'd0);
    chkb("rst:eng_valids", exp_in_tvalid | mul_in_tvalid | exp_out_tready | mul_out_tready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chkb("rst:req_tready", req_tready, 1'b1);

    send(64'd2, 64'd8, 64'd3, 64'd5, 64'd11);
    recv("basic", 64'd8, 64'd8, 1'b0, 0, w);

    ep0 = exp_pulses; mp0 = mul_pulses; bl0 = bad_len;
    send(64'd3, 64'd4, 64'd0, 64'd7, 64'd13);
    recv("k0", 64'd1, 64'd7, 1'b0, 0, w);
    repeat (3) @(negedge clk);
    chk("k0:exp_pulses", word_t'(exp_pulses - ep0), 64'd2);
    chk("k0:mul_pulses", word_t'(mul_pulses - mp0), 64'd1);
    chk("k0:pulse_len", word_t'(bad_len - bl0), 64'd0);

    v0 = vld_cycles;
    run("p1", 64'd0, 64'd0, 64'd5, 64'd0, 64'd1, 0, w);
    chk("p1:latency", word_t'(w), 64'd1);
    run("m_eq_p", 64'd2, 64'd3, 64'd5, 64'd11, 64'd11, 0, w);
    chk("m_eq_p:latency", word_t'(w), 64'd1);
    run("g_ge_p", 64'd20, 64'd3, 64'd5, 64'd4, 64'd11, 0, w);
    chk("bad:no_engine_valid", word_t'(vld_cycles - v0), 64'd0);

    hang_exp = 1'b1; rand_rdy = 1'b0;
    ep0 = exp_pulses; mp0 = mul_pulses; bl0 = bad_len;
    send(64'd3, 64'd4, 64'd5, 64'd6, 64'd7);
    recv("timeout", 64'd0, 64'd0, 1'b1, 0, w);
    chkb("timeout:latency", (w >= 64 && w <= 70), 1'b1);
    repeat (3) @(negedge clk);
    chk("timeout:exp_pulses", word_t'(exp_pulses - ep0), 64'd2);
    chk("timeout:mul_pulses", word_t'(mul_pulses - mp0), 64'd1);
    chk("timeout:pulse_len", word_t'(bad_len - bl0), 64'd0);
    hang_exp = 1'b0; rand_rdy = 1'b1;

    run("hold", 64'd5, 64'd3, 64'd7, 64'd9, 64'd23, 10, w);
    run("after_hold", 64'd6, 64'd2, 64'd9, 64'd4, 64'd29, 0, w);

    fix_dly = 30; a0 = exp_acc; n = 0;
    send(64'd2, 64'd8, 64'd3, 64'd5, 64'd11);
    while (exp_acc < a0 + 2 && n < 200) begin @(negedge clk); n++; end
    chkb("midrst:reached_e2", exp_acc >= a0 + 2, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chkb("midrst:out_tvalid", out_tvalid, 1'b0);
    chkb("midrst:busy", busy, 1'b0);
    chkb("midrst:exp_rst", exp_rst, 1'b1);
    chkb("midrst:mul_rst", mul_rst, 1'b1);
    rst = 1'b0; fix_dly = -1;
    @(negedge clk);
    chkb("midrst:no_output", out_tvalid, 1'b0);
    run("midrst:next", 64'd2, 64'd8, 64'd3, 64'd5, 64'd11, 0, w);

    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0) p = word_t'($urandom_range(2, 1000));
      else p = {$urandom(), $urandom()} | 64'd2;
      g = {$urandom(), $urandom()} % p;
      y = {$urandom(), $urandom()} % p;
      k = {$urandom(), $urandom()};
      m = (i == 7) ? p + word_t'($urandom_range(0, 5)) : {$urandom(), $urandom()} % p;
      run($sformatf("rand%0d", i), g, y, k, m, p, int'($urandom_range(0, 3)), w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
